// File: rtl/async_rx_pkg.sv
// Shared FSM state type, parity-mode constants and baud-accumulator step
// for the async_rx_param receiver.
package async_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxState_t;

    localparam int ParityNone = 0;
    localparam int ParityEven = 1;
    localparam int ParityOdd  = 2;

    // Rounded step so that 2^16 accumulator carries occur Baud*Oversample times a second.
    function automatic logic [16:0] accIncrement(input longint clkFreq, input longint baud,
                                                 input longint oversample);
        longint scaled;
        scaled = (baud * oversample) << 16;
        return 17'((scaled + clkFreq / 2) / clkFreq);
    endfunction

endpackage

// File: rtl/async_rx_baudgen.sv
// Fractional baud-tick generator: 17-bit accumulator whose carry is a one-clk tick.
module async_rx_baudgen #(
    parameter logic [16:0] Increment = 17'd1208
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [16:0] acc;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[15:0]} + Increment;
        end
    end

    assign tick = acc[16];

endmodule

// File: rtl/async_rx_param.sv
// Oversampling asynchronous serial receiver with parity/framing/break/idle detection.
// Define ASYNC_RX_FIFO_EN to replace the single holding register with a FifoDepth-entry FIFO.
module async_rx_param
    import async_rx_pkg::*;
#(
    parameter int ClkFrequency = 100000000,
    parameter int Baud         = 115200,
    parameter int Oversample   = 16,
    parameter int DataBits     = 8,
    parameter int Parity       = ParityNone,
    parameter int StopBits     = 1,
    parameter int IdleBits     = 2,
    parameter int FifoDepth    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RxD,
    output logic [DataBits-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_parity_err,
    output logic                rx_frame_err,
    output logic                rx_overrun,
    output logic                rx_break,
    output logic                rx_idle,
    output logic                rx_endofpacket
);

    if (Oversample != 8 && Oversample != 16) begin : gOversampleCheck
        $error("Oversample must be 8 or 16");
    end
    if (DataBits < 5 || DataBits > 9 || StopBits < 1 || StopBits > 2 || Parity > ParityOdd) begin : gFrameCheck
        $error("illegal DataBits, StopBits or Parity");
    end
    if (FifoDepth < 2 || FifoDepth > 16 || (FifoDepth & (FifoDepth - 1)) != 0) begin : gDepthCheck
        $error("FifoDepth must be a power of 2 in 2..16");
    end

    localparam logic [16:0] Increment =
        accIncrement(longint'(ClkFrequency), longint'(Baud), longint'(Oversample));
    localparam int TickW  = $clog2(Oversample);
    localparam int CntW   = $clog2(DataBits);
    localparam int GapMax = IdleBits * Oversample;
    localparam int GapW   = $clog2(GapMax + 1);
    localparam logic [TickW-1:0] HalfTick = TickW'(Oversample / 2 - 1);
    localparam logic [TickW-1:0] LastTick = TickW'(Oversample - 1);
    localparam logic [CntW-1:0]  LastData = CntW'(DataBits - 1);
    localparam logic [CntW-1:0]  LastStop = CntW'(StopBits - 1);

    typedef struct packed {
        logic [DataBits-1:0] data;
        logic                parityErr;
        logic                frameErr;
    } rxWord_t;

    logic tick;

    async_rx_baudgen #(.Increment(Increment)) uBaudgen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Synchroniser and tick-rate majority filter preset high so reset never looks like a start bit.
    logic [1:0] syncReg;
    logic [2:0] filtReg;
    logic       line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncReg <= '1;
            filtReg <= '1;
        end else begin
            syncReg <= {syncReg[0], RxD};
            if (tick) filtReg <= {filtReg[1:0], syncReg[1]};
        end
    end

    assign line = (filtReg[0] & filtReg[1]) | (filtReg[0] & filtReg[2]) | (filtReg[1] & filtReg[2]);

    rxState_t            state, stateNext;
    logic [TickW-1:0]    tickCnt, tickNext;
    logic [CntW-1:0]     bitCnt, bitNext;
    logic [DataBits-1:0] shiftReg, shiftNext;
    logic                parErr, parErrNext, parBit, parBitNext;
    logic                frameErr, frameErrNext, stopLow, stopLowNext;
    logic                breakHold, holdNext;
    logic                push, breakDet, breakPulse, overrun;
    rxWord_t             pushWord;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tickCnt    <= '0;
            bitCnt     <= '0;
            shiftReg   <= '0;
            parErr     <= 1'b0;
            parBit     <= 1'b0;
            frameErr   <= 1'b0;
            stopLow    <= 1'b0;
            breakHold  <= 1'b0;
            breakPulse <= 1'b0;
        end else begin
            state      <= stateNext;
            tickCnt    <= tickNext;
            bitCnt     <= bitNext;
            shiftReg   <= shiftNext;
            parErr     <= parErrNext;
            parBit     <= parBitNext;
            frameErr   <= frameErrNext;
            stopLow    <= stopLowNext;
            breakHold  <= holdNext;
            breakPulse <= breakDet;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        stateNext    = state;
        tickNext     = tickCnt;
        bitNext      = bitCnt;
        shiftNext    = shiftReg;
        parErrNext   = parErr;
        parBitNext   = parBit;
        frameErrNext = frameErr;
        stopLowNext  = stopLow;
        holdNext     = breakHold;
        push         = 1'b0;
        breakDet     = 1'b0;
        if (tick) begin
            tickNext = tickCnt + 1'b1;
            unique case (state)
                IDLE: begin
                    tickNext = '0;
                    if (line) begin
                        holdNext = 1'b0;
                    end else if (!breakHold) begin
                        stateNext    = START;
                        bitNext      = '0;
                        parErrNext   = 1'b0;
                        parBitNext   = 1'b0;
                        frameErrNext = 1'b0;
                    end
                end
                START: if (tickCnt == HalfTick) begin
                    tickNext  = '0;
                    stateNext = line ? IDLE : DATA;
                end
                DATA: if (tickCnt == LastTick) begin
                    tickNext  = '0;
                    shiftNext = {line, shiftReg[DataBits-1:1]};
                    bitNext   = bitCnt + 1'b1;
                    if (bitCnt == LastData) begin
                        bitNext   = '0;
                        stateNext = (Parity != ParityNone) ? PARITY : STOP;
                    end
                end
                PARITY: if (tickCnt == LastTick) begin
                    tickNext   = '0;
                    parBitNext = line;
                    parErrNext = (^shiftReg) ^ line ^ (Parity == ParityOdd);
                    stateNext  = STOP;
                end
                STOP: if (tickCnt == LastTick) begin
                    tickNext     = '0;
                    bitNext      = bitCnt + 1'b1;
                    frameErrNext = frameErr | !line;
                    if (bitCnt == '0) stopLowNext = !line;
                    if (bitCnt == LastStop) begin
                        push      = 1'b1;
                        bitNext   = '0;
                        stateNext = IDLE;
                        // A break is an all-zero character whose first stop bit is also low.
                        breakDet  = (shiftReg == '0) && !parBit && ((bitCnt == '0) ? !line : stopLow);
                        holdNext  = breakDet;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    assign pushWord = '{data: shiftReg, parityErr: parErr, frameErr: frameErr | !line};

`ifdef ASYNC_RX_FIFO_EN
    localparam int PtrW = $clog2(FifoDepth);

    rxWord_t         mem [FifoDepth];
    logic [PtrW:0]   wrPtr, rdPtr;
    logic            full, empty, pop, doPush;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[PtrW] != rdPtr[PtrW]) && (wrPtr[PtrW-1:0] == rdPtr[PtrW-1:0]);
    assign pop    = !empty && rx_ready;
    assign doPush = push && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            overrun <= 1'b0;
            // NOTE: the storage array is reset too so rx_data reads zero after reset.
            for (int i = 0; i < FifoDepth; i++) mem[i] <= '0;
        end else begin
            overrun <= push && full && !pop;
            if (doPush) begin
                mem[wrPtr[PtrW-1:0]] <= pushWord;
                wrPtr                <= wrPtr + 1'b1;
            end
            if (pop) rdPtr <= rdPtr + 1'b1;
        end
    end

    assign rx_valid = !empty;
    assign {rx_data, rx_parity_err, rx_frame_err} = mem[rdPtr[PtrW-1:0]];
`else
    rxWord_t holdWord;
    logic    holdValid, pop;

    assign pop = holdValid && rx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdWord  <= '0;
            holdValid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= push && holdValid && !pop;
            if (push && (!holdValid || pop)) begin
                holdWord  <= pushWord;
                holdValid <= 1'b1;
            end else if (pop) begin
                holdValid <= 1'b0;
            end
        end
    end

    assign rx_valid = holdValid;
    assign {rx_data, rx_parity_err, rx_frame_err} = holdWord;
`endif

    assign rx_overrun = overrun;
    assign rx_break   = breakPulse;

    logic [GapW-1:0] gapCnt;
    logic            idlePrev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gapCnt   <= GapW'(GapMax);
            idlePrev <= 1'b1;
        end else begin
            idlePrev <= rx_idle;
            if (state != IDLE) gapCnt <= '0;
            else if (tick && gapCnt != GapW'(GapMax)) gapCnt <= gapCnt + 1'b1;
        end
    end

    assign rx_idle        = (gapCnt == GapW'(GapMax));
    assign rx_endofpacket = rx_idle && !idlePrev;

endmodule

// File: tb/tb_async_rx_param.sv
// Self-checking bench for async_rx_param: an 8N1 instance and an 8E1 instance on a fast baud setting.
`timescale 1ns/1ps
module tb_async_rx_param;
    import async_rx_pkg::*;

    localparam int ClkHz    = 2_000_000;
    localparam int BaudRate = 62_500;
    localparam int BitClks  = ClkHz / BaudRate;
`ifdef ASYNC_RX_FIFO_EN
    localparam int Capacity = 4;
`else
    localparam int Capacity = 1;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    logic       clk = 1'b0;
    logic       reset, rxd, rxdE, ready, readyE;
    logic [7:0] rxData, rxDataE;
    logic       rxValid, rxPe, rxFe, rxOverrun, rxBreak, rxIdle, rxEop;
    logic       rxValidE, rxPeE, rxFeE, rxOverrunE, rxBreakE, rxIdleE, rxEopE;

    always #5 clk = ~clk;

    async_rx_param #(
        .ClkFrequency(ClkHz), .Baud(BaudRate), .Oversample(16), .DataBits(8),
        .Parity(0), .StopBits(1), .IdleBits(2), .FifoDepth(4)
    ) dut8n1 (
        .clk(clk), .reset(reset), .RxD(rxd),
        .rx_data(rxData), .rx_valid(rxValid), .rx_ready(ready),
        .rx_parity_err(rxPe), .rx_frame_err(rxFe),
        .rx_overrun(rxOverrun), .rx_break(rxBreak),
        .rx_idle(rxIdle), .rx_endofpacket(rxEop)
    );

    async_rx_param #(
        .ClkFrequency(ClkHz), .Baud(BaudRate), .Oversample(16), .DataBits(8),
        .Parity(1), .StopBits(1), .IdleBits(2), .FifoDepth(4)
    ) dutEven (
        .clk(clk), .reset(reset), .RxD(rxdE),
        .rx_data(rxDataE), .rx_valid(rxValidE), .rx_ready(readyE),
        .rx_parity_err(rxPeE), .rx_frame_err(rxFeE),
        .rx_overrun(rxOverrunE), .rx_break(rxBreakE),
        .rx_idle(rxIdleE), .rx_endofpacket(rxEopE)
    );

    int    checks = 0;
    int    passes = 0;
    word_t rxQ[$];
    word_t rxQE[$];
    int    validCycles = 0, overrunCnt = 0, breakCnt = 0, eopCnt = 0;

    always @(negedge clk) begin
        if (rxValid) validCycles++;
        if (rxValid && ready) rxQ.push_back({rxData, rxPe, rxFe});
        if (rxOverrun) overrunCnt++;
        if (rxBreak) breakCnt++;
        if (rxEop) eopCnt++;
        if (rxValidE && readyE) rxQE.push_back({rxDataE, rxPeE, rxFeE});
    end

    task automatic waitClks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic driveBit(input bit toEven, input logic b);
        if (toEven) rxdE = b;
        else rxd = b;
        waitClks(BitClks);
    endtask

    // Frame on the wire: start, 8 data LSB first, optional even-parity bit (optionally corrupted), stop.
    task automatic sendFrame(input bit toEven, input logic [7:0] d, input bit withPar, input bit invPar);
        logic pbit;
        driveBit(toEven, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(toEven, d[i]);
        if (withPar) begin
            pbit = (^d) ^ invPar;
            driveBit(toEven, pbit);
        end
        driveBit(toEven, 1'b1);
    endtask

    task automatic test_reset();
        logic [14:0] exp, obs;
        exp = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rxd = 1'b1; rxdE = 1'b1; ready = 1'b1; readyE = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        obs = {rxData, rxValid, rxPe, rxFe, rxOverrun, rxBreak, rxIdle, rxEop};
        checks++;
        if (obs !== exp) $display("FAIL reset_during: outputs %h expected %h", obs, exp);
        else passes++;
        #2 reset = 1'b0;
        waitClks(BitClks);
        @(negedge clk);
        obs = {rxData, rxValid, rxPe, rxFe, rxOverrun, rxBreak, rxIdle, rxEop};
        checks++;
        if (obs !== exp) $display("FAIL reset_after: outputs %h expected %h", obs, exp);
        else passes++;
        obs = {rxDataE, rxValidE, rxPeE, rxFeE, rxOverrunE, rxBreakE, rxIdleE, rxEopE};
        checks++;
        if (obs !== exp) $display("FAIL reset_after_even: outputs %h expected %h", obs, exp);
        else passes++;
        waitClks(1);
    endtask

    task automatic test_basic();
        int    base, v0, nSent;
        word_t expQ[$];
        word_t expW;
        base = rxQ.size();
        v0   = validCycles;
        sendFrame(1'b0, 8'hA5, 1'b0, 1'b0);
        waitClks(2 * BitClks);
        checks++;
        if (rxQ.size() - base != 1) $display("FAIL a5_count: words %0d expected 1", rxQ.size() - base);
        else passes++;
        checks++;
        if (rxQ.size() - base != 1 || rxQ[base] !== word_t'({8'hA5, 1'b0, 1'b0}))
            $display("FAIL a5_word: got %h expected %h", (rxQ.size() > base) ? rxQ[base] : word_t'('x),
                     word_t'({8'hA5, 1'b0, 1'b0}));
        else passes++;
        checks++;
        if (validCycles - v0 != 1) $display("FAIL a5_valid_width: %0d cycles expected 1", validCycles - v0);
        else passes++;

        base  = rxQ.size();
        nSent = 6;
        for (int k = 0; k < nSent; k++) begin
            expW.d  = 8'($urandom);
            expW.pe = 1'b0;
            expW.fe = 1'b0;
            expQ.push_back(expW);
            sendFrame(1'b0, expW.d, 1'b0, 1'b0);
            waitClks($urandom_range(0, 20));
        end
        waitClks(2 * BitClks);
        checks++;
        if (rxQ.size() - base != nSent) $display("FAIL rand_count: words %0d expected %0d", rxQ.size() - base, nSent);
        else passes++;
        for (int k = 0; k < nSent && k < rxQ.size() - base; k++) begin
            checks++;
            if (rxQ[base + k] !== expQ[k]) $display("FAIL rand_word%0d: got %h expected %h", k, rxQ[base + k], expQ[k]);
            else passes++;
        end
    endtask

    task automatic test_parity();
        int    base, nSent;
        word_t expQ[$];
        word_t expW;
        logic  inv, pbit;
        base  = rxQE.size();
        nSent = 7;
        for (int k = 0; k < nSent; k++) begin
            expW.d = (k == 0) ? 8'h3C : 8'($urandom);
            inv    = (k == 0) ? 1'b1 : 1'($urandom);
            pbit   = (^expW.d) ^ inv;
            expW.pe = ((^expW.d) ^ pbit) == 1'b1;
            expW.fe = 1'b0;
            expQ.push_back(expW);
            sendFrame(1'b1, expW.d, 1'b1, inv);
            waitClks($urandom_range(0, 20));
        end
        waitClks(2 * BitClks);
        checks++;
        if (rxQE.size() - base != nSent) $display("FAIL par_count: words %0d expected %0d", rxQE.size() - base, nSent);
        else passes++;
        for (int k = 0; k < nSent && k < rxQE.size() - base; k++) begin
            checks++;
            if (rxQE[base + k] !== expQ[k]) $display("FAIL par_word%0d: got %h expected %h", k, rxQE[base + k], expQ[k]);
            else passes++;
        end
    endtask

    task automatic test_glitch();
        int base;
        base = rxQ.size();
        rxd = 1'b0;
        waitClks(BitClks * 3 / 10);
        rxd = 1'b1;
        waitClks(3 * BitClks);
        checks++;
        if (rxQ.size() != base) $display("FAIL glitch_word: words %0d expected 0", rxQ.size() - base);
        else passes++;
        checks++;
        if (dut8n1.state !== IDLE) $display("FAIL glitch_state: state %0d expected %0d", dut8n1.state, IDLE);
        else passes++;
    endtask

    task automatic test_break();
        int    base, b0;
        word_t expW;
        base = rxQ.size();
        b0   = breakCnt;
        rxd  = 1'b0;
        waitClks(12 * BitClks);
        checks++;
        if (rxQ.size() - base != 1) $display("FAIL break_words_low: words %0d expected 1", rxQ.size() - base);
        else passes++;
        rxd = 1'b1;
        waitClks(3 * BitClks);
        expW = {8'h00, 1'b0, 1'b1};
        checks++;
        if (rxQ.size() - base != 1 || rxQ[base] !== expW)
            $display("FAIL break_word: got %h (count %0d) expected %h", (rxQ.size() > base) ? rxQ[base] : word_t'('x),
                     rxQ.size() - base, expW);
        else passes++;
        checks++;
        if (breakCnt - b0 != 1) $display("FAIL break_pulse: pulses %0d expected 1", breakCnt - b0);
        else passes++;
        base = rxQ.size();
        sendFrame(1'b0, 8'h5A, 1'b0, 1'b0);
        waitClks(2 * BitClks);
        expW = {8'h5A, 1'b0, 1'b0};
        checks++;
        if (rxQ.size() - base != 1 || rxQ[base] !== expW)
            $display("FAIL break_recover: got %h (count %0d) expected %h", (rxQ.size() > base) ? rxQ[base] : word_t'('x),
                     rxQ.size() - base, expW);
        else passes++;
    endtask

    task automatic test_overrun();
        int base, o0;
        base  = rxQ.size();
        o0    = overrunCnt;
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) sendFrame(1'b0, 8'(k), 1'b0, 1'b0);
        waitClks(2 * BitClks);
        checks++;
        if (overrunCnt - o0 != 5 - Capacity) $display("FAIL ovr_pulses: pulses %0d expected %0d", overrunCnt - o0, 5 - Capacity);
        else passes++;
        checks++;
        if (rxValid !== 1'b1) $display("FAIL ovr_valid: rx_valid %b expected 1", rxValid);
        else passes++;
        ready = 1'b1;
        waitClks(10);
        checks++;
        if (rxQ.size() - base != Capacity) $display("FAIL ovr_pops: words %0d expected %0d", rxQ.size() - base, Capacity);
        else passes++;
        for (int k = 0; k < Capacity && k < rxQ.size() - base; k++) begin
            checks++;
            if (rxQ[base + k].d !== 8'(k + 1)) $display("FAIL ovr_word%0d: got %h expected %h", k, rxQ[base + k].d, 8'(k + 1));
            else passes++;
        end
        checks++;
        if (rxValid !== 1'b0) $display("FAIL ovr_drained: rx_valid %b expected 0", rxValid);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int base, e0, waited;
        waitClks(3 * BitClks);
        base = rxQ.size();
        e0   = eopCnt;
        sendFrame(1'b0, 8'h11, 1'b0, 1'b0);
        checks++;
        if (rxIdle !== 1'b0) $display("FAIL b2b_idle1: rx_idle %b expected 0", rxIdle);
        else passes++;
        sendFrame(1'b0, 8'h22, 1'b0, 1'b0);
        checks++;
        if (rxIdle !== 1'b0) $display("FAIL b2b_idle2: rx_idle %b expected 0", rxIdle);
        else passes++;
        sendFrame(1'b0, 8'h33, 1'b0, 1'b0);
        checks++;
        if (eopCnt != e0) $display("FAIL b2b_eop_early: pulses %0d expected 0", eopCnt - e0);
        else passes++;
        waited = 0;
        while (eopCnt == e0 && waited < 4 * BitClks) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited < BitClks || waited > 3 * BitClks)
            $display("FAIL b2b_eop_delay: %0d clk after frame end expected %0d..%0d", waited, BitClks, 3 * BitClks);
        else passes++;
        waitClks(3 * BitClks);
        checks++;
        if (eopCnt - e0 != 1) $display("FAIL b2b_eop_count: pulses %0d expected 1", eopCnt - e0);
        else passes++;
        checks++;
        if (rxQ.size() - base != 3 || rxQ[base].d !== 8'h11 || rxQ[base + 1].d !== 8'h22 || rxQ[base + 2].d !== 8'h33)
            $display("FAIL b2b_words: count %0d expected 3 words 11 22 33", rxQ.size() - base);
        else passes++;
    endtask

    task automatic test_mid_reset();
        int base, b0, o0, e0;
        base = rxQ.size();
        b0 = breakCnt; o0 = overrunCnt; e0 = eopCnt;
        for (int i = 0; i < 4; i++) driveBit(1'b0, 1'b0);
        #2 reset = 1'b1;
        rxd = 1'b1;
        waitClks(5);
        reset = 1'b0;
        waitClks(12 * BitClks);
        checks++;
        if (rxQ.size() != base || breakCnt != b0 || overrunCnt != o0 || eopCnt != e0)
            $display("FAIL midreset_pulses: words %0d breaks %0d overruns %0d eops %0d expected all 0",
                     rxQ.size() - base, breakCnt - b0, overrunCnt - o0, eopCnt - e0);
        else passes++;
        checks++;
        if (rxValid !== 1'b0 || rxIdle !== 1'b1) $display("FAIL midreset_state: valid %b idle %b expected 0 1", rxValid, rxIdle);
        else passes++;
    endtask

    initial begin
        reset = 1'b1;
        rxd = 1'b1; rxdE = 1'b1; ready = 1'b1; readyE = 1'b1;
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_break();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
